// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-memory port arbiter.
// Owner codes, controller instruction encodings and FSM states.
package mem_port_arbiter_pkg;

  localparam logic OWNER_VGA = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

  localparam logic [2:0] MEM_INSTR_READ  = 3'b001;
  localparam logic [2:0] MEM_INSTR_WRITE = 3'b000;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } arb_state_t;

  function automatic logic is_read(
    input logic [2:0] instr
  );
    return instr == MEM_INSTR_READ;
  endfunction

endpackage

// File: rtl/mem_tag_fifo.sv
// In-order tracker of outstanding read bursts ({owner, bl} per entry).
// Ports: push/din in, pop in, head/full/empty out; async active-high rst.
module mem_tag_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + AW'(1);
      end
      if (do_pop) begin
        rp <= rp + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory command/read port between VGA (priority) and CPU.
// Ports: vga_*/cpu_* client sides, mem_* controller side, rd_orphan.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TAG_DEPTH = 4,
  parameter int BL_W      = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            calib_done,
  input  logic            vga_req,
  input  logic [2:0]      vga_instr,
  input  logic [BL_W-1:0] vga_bl,
  input  logic [29:0]     vga_addr,
  output logic            vga_ack,
  input  logic            vga_rd_en,
  output logic            vga_rd_empty,
  input  logic            cpu_req,
  input  logic [2:0]      cpu_instr,
  input  logic [BL_W-1:0] cpu_bl,
  input  logic [29:0]     cpu_addr,
  output logic            cpu_ack,
  input  logic            cpu_rd_en,
  output logic            cpu_rd_empty,
  output logic [31:0]     rd_data,
  output logic            mem_cmd_en,
  output logic [2:0]      mem_cmd_instr,
  output logic [BL_W-1:0] mem_cmd_bl,
  output logic [29:0]     mem_cmd_byte_addr,
  input  logic            mem_cmd_full,
  output logic            mem_rd_en,
  input  logic [31:0]     mem_rd_data,
  input  logic            mem_rd_empty,
  output logic            rd_orphan
);

  localparam int TW = 1 + BL_W;

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic            gnt_vga;
  logic            gnt_cpu;
  logic            vga_ok;
  logic            cpu_ok;
  logic            tag_push;
  logic            tag_pop;
  logic [TW-1:0]   tag_din;
  logic [TW-1:0]   tag_head;
  logic            tag_full;
  logic            tag_empty;
  logic            head_owner;
  logic [BL_W-1:0] head_bl;
  logic [BL_W-1:0] wcnt;
  logic            own_vga;
  logic            own_cpu;

  // A read needs a free tag slot; writes never return data.
  assign vga_ok = vga_req & (~is_read(vga_instr) | ~tag_full);
  assign cpu_ok = cpu_req & (~is_read(cpu_instr) | ~tag_full);

  always_comb begin
    state_nxt = state;
    gnt_vga   = 1'b0;
    gnt_cpu   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (calib_done & ~mem_cmd_full) begin
          if (vga_ok) begin
            gnt_vga = 1'b1;
          end else if (cpu_ok) begin
            gnt_cpu = 1'b1;
          end
        end
        if (gnt_vga | gnt_cpu) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobe derives from state so reset removes it without a clock.
  assign mem_cmd_en = (state == S_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_ack           <= 1'b0;
      cpu_ack           <= 1'b0;
      mem_cmd_instr     <= '0;
      mem_cmd_bl        <= '0;
      mem_cmd_byte_addr <= '0;
    end else begin
      vga_ack <= gnt_vga;
      cpu_ack <= gnt_cpu;
      unique case (1'b1)
        gnt_vga: begin
          mem_cmd_instr     <= vga_instr;
          mem_cmd_bl        <= vga_bl;
          mem_cmd_byte_addr <= vga_addr;
        end
        gnt_cpu: begin
          mem_cmd_instr     <= cpu_instr;
          mem_cmd_bl        <= cpu_bl;
          mem_cmd_byte_addr <= cpu_addr;
        end
        default: begin
          mem_cmd_instr     <= mem_cmd_instr;
          mem_cmd_bl        <= mem_cmd_bl;
          mem_cmd_byte_addr <= mem_cmd_byte_addr;
        end
      endcase
    end
  end

  assign tag_push = (gnt_vga & is_read(vga_instr))
                  | (gnt_cpu & is_read(cpu_instr));
  assign tag_din  = gnt_vga ? {OWNER_VGA, vga_bl}
                            : {OWNER_CPU, cpu_bl};

  mem_tag_fifo #(
    .W     (TW),
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (tag_din),
    .pop   (tag_pop),
    .head  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign head_owner = tag_head[BL_W];
  assign head_bl    = tag_head[BL_W-1:0];

  assign own_vga = ~tag_empty & (head_owner == OWNER_VGA);
  assign own_cpu = ~tag_empty & (head_owner == OWNER_CPU);

  assign vga_rd_empty = mem_rd_empty | ~own_vga;
  assign cpu_rd_empty = mem_rd_empty | ~own_cpu;

  assign mem_rd_en = (vga_rd_en & ~vga_rd_empty)
                   | (cpu_rd_en & ~cpu_rd_empty);

  assign rd_data = mem_rd_data;

  // Last word of the head burst retires its tag.
  assign tag_pop = mem_rd_en & (wcnt == head_bl);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (tag_pop) begin
      wcnt <= '0;
    end else if (mem_rd_en) begin
      wcnt <= wcnt + BL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_orphan <= 1'b0;
    end else if (~mem_rd_empty & tag_empty) begin
      rd_orphan <= 1'b1;
    end
  end

endmodule
